// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the matrix-keypad front end and its consumers.
//   NUM_ROWS / NUM_COLS : keypad geometry (4x4)
//   NO_KEY              : keynum value meaning "no key held"
//   state_t             : scanner state encoding
//   low_col()           : index of the lowest-numbered low (pressed) column
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [4:0] NO_KEY = 5'b10000;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    HOLD     = 2'd3
  } state_t;

  // Columns are active-low. Scanning from the top index down means the
  // lowest low bit is the last one written, so it wins when several
  // columns are low together.
  function automatic logic [1:0] low_col(input logic [NUM_COLS-1:0] c);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!c[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
// Two-flop synchronizer for the asynchronous keypad column lines.
// Resets to all-ones, which is the "no key" level of the pulled-up columns.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   d     : asynchronous input bus
//   q     : synchronized output bus (two cycles of latency)
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int WIDTH = NUM_COLS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// Matrix-keypad front end: drives one row low at a time, samples the
// columns once per row dwell, debounces press and release, and publishes
// a key code with a one-cycle strobe per accepted press.
//   SCAN_DIV     : clock cycles each row is driven (>= 4)
//   DEBOUNCE_CNT : consecutive matching samples to accept press/release (>= 1)
//   clk          : system clock
//   reset        : asynchronous, active-high reset
//   row          : active-low row drive, exactly one bit low
//   col          : active-low column inputs (asynchronous, pulled up)
//   keynum       : {1'b0, row_idx, col_idx} while a key is held, else NO_KEY
//   pulse        : one-cycle strobe, one cycle after keynum becomes valid
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic                clk,
  input  logic                reset,
  output logic [NUM_ROWS-1:0] row,
  input  logic [NUM_COLS-1:0] col,
  output logic [4:0]          keynum,
  output logic                pulse
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [NUM_COLS-1:0] col_s;
  logic [DW-1:0]       dwell;
  state_t              state, state_next;
  logic [1:0]          row_idx, row_next;
  logic [3:0]          cand, cand_next;
  logic [CW-1:0]       match, match_next;
  logic [CW-1:0]       rel_cnt, rel_next;
  logic [4:0]          keynum_next;
  logic                pulse_arm;

  logic                sample;
  logic                hit;
  logic [3:0]          hit_code;
  logic                cand_held;

  keypad_sync #(
    .WIDTH(NUM_COLS)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (col),
    .q    (col_s)
  );

  // The dwell counter free-runs regardless of state, so the sample point
  // is a fixed cadence and state changes never stretch a row's dwell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell <= '0;
    end else if (dwell == DWELL_LAST) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  assign sample   = (dwell == DWELL_LAST);
  assign hit      = ~&col_s;
  assign hit_code = {row_idx, low_col(col_s)};

  // During HOLD the candidate's row is still driven, so the candidate is
  // held exactly when its own column is low. Checking that column directly
  // (rather than the lowest-column code) keeps a second key in the same row
  // from being mistaken for a release.
  assign cand_held = ~col_s[cand[1:0]];

  assign row = ~(NUM_ROWS'(1) << row_idx);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SCAN;
      row_idx <= '0;
      cand    <= '0;
      match   <= '0;
      rel_cnt <= '0;
      keynum  <= NO_KEY;
    end else begin
      state   <= state_next;
      row_idx <= row_next;
      cand    <= cand_next;
      match   <= match_next;
      rel_cnt <= rel_next;
      keynum  <= keynum_next;
    end
  end

  // Next-state and datapath logic. Everything except PRESSED only acts on
  // sample cycles; the row is only advanced when leaving for or staying in
  // SCAN, never while a candidate key is being tracked.
  always_comb begin
    state_next  = state;
    row_next    = row_idx;
    cand_next   = cand;
    match_next  = match;
    rel_next    = rel_cnt;
    keynum_next = keynum;

    case (state)
      SCAN: begin
        if (sample) begin
          if (hit) begin
            cand_next  = hit_code;
            match_next = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              state_next = PRESSED;
            end else begin
              state_next = DEBOUNCE;
            end
          end else begin
            row_next = row_idx + 1'b1;
          end
        end
      end

      DEBOUNCE: begin
        if (sample) begin
          if (hit && (hit_code == cand)) begin
            match_next = match + 1'b1;
            if (match == CNT_LAST) begin
              state_next = PRESSED;
            end
          end else begin
            state_next = SCAN;
            match_next = '0;
            row_next   = row_idx + 1'b1;
          end
        end
      end

      PRESSED: begin
        keynum_next = {1'b0, cand};
        rel_next    = '0;
        state_next  = HOLD;
      end

      HOLD: begin
        if (sample) begin
          if (cand_held) begin
            rel_next = '0;
          end else if (rel_cnt == CNT_LAST) begin
            keynum_next = NO_KEY;
            rel_next    = '0;
            match_next  = '0;
            state_next  = SCAN;
            row_next    = row_idx + 1'b1;
          end else begin
            rel_next = rel_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase
  end

  // The strobe is delayed one extra cycle behind keynum so the consumer
  // always sees a settled code for a full cycle before and during pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_arm <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      pulse_arm <= (state == PRESSED);
      pulse     <= pulse_arm;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Directed bench for keypad_scan with SCAN_DIV = 4 and DEBOUNCE_CNT = 3.
// A behavioural keypad pulls column c low when key (r,c) is pressed and
// row r is driven low. The bench keeps its own cycle count since reset
// release; with SCAN_DIV = 4 the sample edges are the ones after which
// that count is a multiple of 4.
module tb_keypad_scan;

  localparam logic [4:0] NO_KEY = 5'b10000;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] keynum;
  logic       pulse;

  logic [15:0] pressed;

  int compared;
  int mismatched;
  int cyc;

  int         pulse_count;
  logic [4:0] pulse_key;
  logic [4:0] pulse_prev_key;
  int         pulse_phase;
  logic [4:0] prev_key;
  logic       prev_pulse;
  int         double_pulse;
  int         key_active;
  logic       hold_watch;
  logic [4:0] hold_key;
  int         hold_bad;
  int         rel_base;

  keypad_scan #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .row   (row),
    .col   (col),
    .keynum(keynum),
    .pulse (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row[r]) begin
          col[c] = 1'b0;
        end
      end
    end
  end

  // Cycles since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
    end
  end

  // Observes the outputs on the falling edge and records pulse context.
  always @(negedge clk) begin
    if (!reset) begin
      if (pulse) begin
        pulse_count    = pulse_count + 1;
        pulse_key      = keynum;
        pulse_prev_key = prev_key;
        pulse_phase    = cyc % 4;
        if (prev_pulse) begin
          double_pulse = double_pulse + 1;
        end
      end
      if (keynum != NO_KEY) begin
        key_active = key_active + 1;
      end
      if (hold_watch && (keynum != hold_key)) begin
        hold_bad = hold_bad + 1;
      end
    end
    prev_key   = keynum;
    prev_pulse = pulse;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared = compared + 1;
    if (actual !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitCyc(input int n);
    while (cyc < n) begin
      stepCycle();
    end
  endtask

  // Press keys, wait (bounded) for the strobe and check its context.
  task automatic pressAndWait(input logic [15:0] keys, input logic [4:0] exp_key,
                              input string tag);
    pulse_count  = 0;
    double_pulse = 0;
    applyStimulus(keys);
    for (int i = 0; i < 200 && pulse_count == 0; i++) begin
      stepCycle();
    end
    checkOutput({tag, "_pulseSeen"}, pulse_count, 1);
    checkOutput({tag, "_keyAtPulse"}, pulse_key, exp_key);
    checkOutput({tag, "_keyBeforePulse"}, pulse_prev_key, exp_key);
    checkOutput({tag, "_pulsePhase"}, pulse_phase, 2);
    stepCycle();
    checkOutput({tag, "_pulseOneCycle"}, pulse, 1'b0);
  endtask

  // Release everything now; the first sample that sees the release is the
  // first multiple of 4 at least 3 edges away (2-flop synchronizer), and
  // keynum clears on the edge of the third such sample.
  task automatic releaseAndCheck(input logic [4:0] exp_key, input logic [3:0] exp_row,
                                 input string tag);
    int c0;
    int s1;
    c0 = cyc;
    applyStimulus(16'h0000);
    s1 = ((c0 + 6) / 4) * 4;
    rel_base = s1 + 8;
    waitCyc(rel_base - 1);
    checkOutput({tag, "_keyBeforeRelease"}, keynum, exp_key);
    stepCycle();
    checkOutput({tag, "_keyAfterRelease"}, keynum, NO_KEY);
    checkOutput({tag, "_rowAfterRelease"}, row, exp_row);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared     = 0;
    mismatched   = 0;
    pulse_count  = 0;
    double_pulse = 0;
    key_active   = 0;
    hold_watch   = 1'b0;
    hold_key     = NO_KEY;
    hold_bad     = 0;
    pulse_key    = NO_KEY;
    pulse_prev_key = NO_KEY;
    pulse_phase  = 0;
    rel_base     = 0;
    pressed      = 16'h0000;
    reset        = 1'b1;

    #1;
    checkOutput("resetRow", row, 4'b1110);
    checkOutput("resetKeynum", keynum, NO_KEY);
    checkOutput("resetPulse", pulse, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    // Idle scanning: one row step per sample.
    waitCyc(5);
    checkOutput("scanRow1", row, 4'b1101);
    waitCyc(9);
    checkOutput("scanRow2", row, 4'b1011);
    waitCyc(13);
    checkOutput("scanRow3", row, 4'b0111);
    waitCyc(17);
    checkOutput("scanRow0", row, 4'b1110);

    // Asynchronous reset in the middle of a dwell with row 1 driven.
    waitCyc(22);
    checkOutput("midDwellRow", row, 4'b1101);
    reset = 1'b1;
    #1;
    checkOutput("asyncResetRow", row, 4'b1110);
    checkOutput("asyncResetKeynum", keynum, NO_KEY);
    checkOutput("asyncResetPulse", pulse, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Stable press of key (1,1).
    pressAndWait(16'h0020, 5'd5, "key11");
    repeat (20) stepCycle();
    checkOutput("key11_singlePulse", pulse_count, 1);
    checkOutput("key11_keyHeld", keynum, 5'd5);
    releaseAndCheck(5'd5, 4'b1011, "key11");

    // Bounce on key (2,0): two matching samples, release, again.
    pulse_count = 0;
    key_active  = 0;
    applyStimulus(16'h0100);
    waitCyc(rel_base + 8);
    applyStimulus(16'h0000);
    waitCyc(rel_base + 24);
    applyStimulus(16'h0100);
    waitCyc(rel_base + 32);
    applyStimulus(16'h0000);
    waitCyc(rel_base + 37);
    checkOutput("bounce_rowAdvanced", row, 4'b0111);
    checkOutput("bounce_noPulse", pulse_count, 0);
    checkOutput("bounce_noKey", key_active, 0);
    checkOutput("bounce_keynum", keynum, NO_KEY);

    // Two keys on row 3: lowest column wins.
    pressAndWait(16'hC000, 5'd14, "row3dual");
    repeat (12) stepCycle();
    checkOutput("row3dual_singlePulse", pulse_count, 1);
    releaseAndCheck(5'd14, 4'b1110, "row3dual");

    // Key (0,0) held for 100 samples.
    pressAndWait(16'h0001, 5'd0, "longHold");
    hold_key   = 5'd0;
    hold_bad   = 0;
    hold_watch = 1'b1;
    repeat (400) stepCycle();
    hold_watch = 1'b0;
    checkOutput("longHold_singlePulse", pulse_count, 1);
    checkOutput("longHold_noDoublePulse", double_pulse, 0);
    checkOutput("longHold_keyStable", hold_bad, 0);
    releaseAndCheck(5'd0, 4'b1101, "longHold");

    // Reset during DEBOUNCE after two matching samples, then re-detect.
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    pulse_count = 0;
    applyStimulus(16'h0001);
    waitCyc(9);
    reset = 1'b1;
    #1;
    checkOutput("dbReset_keynum", keynum, NO_KEY);
    checkOutput("dbReset_pulse", pulse, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    waitCyc(12);
    checkOutput("dbReset_noEarlyPulse", pulse_count, 0);
    checkOutput("dbReset_keyAt12", keynum, NO_KEY);
    waitCyc(13);
    checkOutput("dbReset_keyAt13", keynum, 5'd0);
    checkOutput("dbReset_pulseAt13", pulse, 1'b0);
    waitCyc(14);
    checkOutput("dbReset_pulseAt14", pulse, 1'b1);
    checkOutput("dbReset_keyAt14", keynum, 5'd0);
    waitCyc(15);
    checkOutput("dbReset_pulseAt15", pulse, 1'b0);
    checkOutput("dbReset_pulseCount", pulse_count, 1);
    releaseAndCheck(5'd0, 4'b1101, "dbReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad front end for the two-channel DDS controller. Drives a 4x4 keypad's rows, samples its columns, debounces, and emits the 5-bit key code `keynum` plus a one-cycle `pulse` per accepted press. These are the exact signals the FPreg frequency/phase register block consumes. This block is the producer end of that key interface; FPreg is the consumer.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each row is driven (dwell); legal range >= 4.
- `DEBOUNCE_CNT`, default 10: consecutive matching samples needed to accept a press or a release; legal range >= 1.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `row` output 4: row drive, active-low, exactly one bit low at any time.
- `col` input 4: keypad columns, active-low, externally pulled up, asynchronous.
- `keynum` output 5: key code. Value is {1'b0, row_idx[1:0], col_idx[1:0]} (0..15). 5'b10000 (NO_KEY) means no key is held.
- `pulse` output 1: one-cycle strobe for a newly accepted press.

## Operation
- `col` passes through a 2-flop synchronizer reset to 4'b1111; all logic uses the synchronized value `col_s`.
- A dwell counter runs 0..SCAN_DIV-1.
  - Sample point: the cycle where the counter equals SCAN_DIV-1.
  - "Hit" means any bit of `col_s` is low at the sample point.
  - Hit column: the lowest-index low bit.
- States:
  - SCAN
    - At a sample with no hit, advance the row 0->1->2->3->0.
    - At a hit, latch cand = {row_idx, col_idx}, set match = 1, go to DEBOUNCE. The row is not advanced.
  - DEBOUNCE
    - The row stays fixed.
    - Each sample whose hit code equals cand increments match.
    - When match reaches DEBOUNCE_CNT, go to PRESSED.
    - Any sample with no hit or a different code returns to SCAN with the row advanced.
  - PRESSED
    - For one cycle, `keynum` <= cand.
    - Go to HOLD and assert `pulse` on the next cycle.
  - HOLD
    - The row stays fixed.
    - A sample whose hit code equals cand clears rel_cnt.
    - Any other sample increments rel_cnt.
    - When rel_cnt reaches DEBOUNCE_CNT, set `keynum` <= NO_KEY and return to SCAN with the row advanced.
- When DEBOUNCE_CNT = 1, acceptance happens at the first hit sample: SCAN goes straight to PRESSED.
- A second key pressed while one is in HOLD is ignored. Its code never matches cand, but it does not count as release while cand is still held.
- The dwell counter free-runs in every state and is never reset on a state change.

## Timing
- Reset values:
  - `row` = 4'b1110 (row 0).
  - `keynum` = 5'b10000.
  - `pulse` = 0.
  - state = SCAN, dwell = 0, match = 0, rel_cnt = 0.
- Reset asserted in any state returns all of the above immediately. No `pulse` is produced for a press that has not reached PRESSED.
- Input latency is 2 cycles (synchronizer). SCAN_DIV >= 4 guarantees `col_s` has settled before each sample.
- Press latency, relative to the sample edge where match reaches DEBOUNCE_CNT:
  - `keynum` is valid 1 cycle later.
  - `pulse` is high 2 cycles later, for exactly 1 cycle.
  - `keynum` is therefore stable for at least one cycle before `pulse` and throughout it.
- `keynum` holds the code from PRESSED until the release sample. It becomes NO_KEY on the cycle after that sample.
- There is exactly one `pulse` per press-release sequence, regardless of hold duration.
- A row change takes effect on the cycle after a sample.

## Structure
- Shared package `keypad_pkg`:
  - `NO_KEY` = 5'b10000.
  - `NUM_ROWS` = 4, `NUM_COLS` = 4.
  - State enum {SCAN, DEBOUNCE, PRESSED, HOLD}.
  - This package is imported by FPreg for `NO_KEY`.
- One sub-module, `keypad_sync`: parameterized-width 2-flop synchronizer with async reset to all-ones.
- Counter widths: $clog2(SCAN_DIV) for the dwell counter; $clog2(DEBOUNCE_CNT+1) for match and rel_cnt.

## Test plan
Bench keypad model: col[c] = 0 iff key (r,c) is pressed and row[r] == 0. Run with SCAN_DIV = 4 and DEBOUNCE_CNT = 3.
- Reset: assert `reset` mid-dwell -> `row` = 4'b1110, `keynum` = 5'b10000, `pulse` = 0 in the same cycle (asynchronous).
- Stable press of key (1,1) -> `keynum` = 5'd5 one cycle before a single-cycle `pulse`. After release, `keynum` = 5'b10000 one cycle after the 3rd non-matching sample.
- Bounce: key (2,0) pressed for 2 samples, released, pressed 2 samples, released -> no `pulse`, `keynum` stays 5'b10000.
- Row 3, cols 2 and 3 pressed together -> `keynum` = 5'd14 (lowest column wins), one `pulse`.
- Key (0,0) held for 100 samples -> exactly one `pulse`. `keynum` = 5'd0 throughout the hold.
- `reset` asserted during DEBOUNCE (after 2 matching samples) -> no `pulse`. After reset release, scanning restarts at row 0 and the press is re-detected normally.
